// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Ties alternate between requesters; a lock keeps ownership for atomic read-modify-write.
module ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dataout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Widened so the comparison against the incremented count cannot wrap.
  localparam logic [4:0] LOCK_LIMIT = 5'(LOCK_MAX);

  state_t              state_r;
  state_t              state_next_s;
  logic                last_r;
  logic                last_next_s;
  logic [3:0]          idle_cnt_r;
  logic [3:0]          idle_cnt_next_s;
  logic [4:0]          idle_inc_s;
  logic                rvalid0_r;
  logic                rvalid1_r;
  logic                gnt0_s;
  logic                gnt1_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_datain_s;
  logic                ram_we_s;

  assign idle_inc_s = {1'b0, idle_cnt_r} + 5'd1;

  // Grant decode: owner-only while locked, otherwise alternate on ties.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0 && req1) begin
            if (last_r) begin
              gnt0_s = 1'b1;
            end else begin
              gnt1_s = 1'b1;
            end
          end else begin
            gnt0_s = req0;
            gnt1_s = req1;
          end
        end
        OWN0:    gnt0_s = req0;
        OWN1:    gnt1_s = req1;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Next-state, tie-break history and lock idle counter.
  always_comb begin
    state_next_s    = state_r;
    last_next_s     = last_r;
    idle_cnt_next_s = idle_cnt_r;
    if (gnt0_s) begin
      last_next_s     = 1'b0;
      idle_cnt_next_s = 4'd0;
      if (lock0) begin
        state_next_s = OWN0;
      end else begin
        state_next_s = IDLE;
      end
    end else if (gnt1_s) begin
      last_next_s     = 1'b1;
      idle_cnt_next_s = 4'd0;
      if (lock1) begin
        state_next_s = OWN1;
      end else begin
        state_next_s = IDLE;
      end
    end else begin
      // No grant while owning means the owner is idle this cycle.
      case (state_r)
        IDLE: idle_cnt_next_s = 4'd0;
        OWN0: begin
          if (!lock0 || (idle_inc_s >= LOCK_LIMIT)) begin
            state_next_s    = IDLE;
            idle_cnt_next_s = 4'd0;
          end else begin
            idle_cnt_next_s = idle_inc_s[3:0];
          end
        end
        OWN1: begin
          if (!lock1 || (idle_inc_s >= LOCK_LIMIT)) begin
            state_next_s    = IDLE;
            idle_cnt_next_s = 4'd0;
          end else begin
            idle_cnt_next_s = idle_inc_s[3:0];
          end
        end
        default: begin
          state_next_s    = IDLE;
          idle_cnt_next_s = 4'd0;
        end
      endcase
    end
  end

  // State registers and read-valid pipeline aligned with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      idle_cnt_r <= 4'd0;
      rvalid0_r  <= 1'b0;
      rvalid1_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      last_r     <= last_next_s;
      idle_cnt_r <= idle_cnt_next_s;
      rvalid0_r  <= gnt0_s & ~we0;
      rvalid1_r  <= gnt1_s & ~we1;
    end
  end

  // RAM port steering from the granted requester; quiet bus when nobody is granted.
  always_comb begin
    ram_addr_s   = {ADDR_W{1'b0}};
    ram_datain_s = {DATA_W{1'b0}};
    ram_we_s     = 1'b0;
    if (gnt0_s) begin
      ram_addr_s   = addr0;
      ram_datain_s = wdata0;
      ram_we_s     = we0;
    end else if (gnt1_s) begin
      ram_addr_s   = addr1;
      ram_datain_s = wdata1;
      ram_we_s     = we1;
    end else begin
      ram_addr_s   = {ADDR_W{1'b0}};
      ram_datain_s = {DATA_W{1'b0}};
      ram_we_s     = 1'b0;
    end
  end

  assign gnt0       = gnt0_s;
  assign gnt1       = gnt1_s;
  assign rvalid0    = rvalid0_r;
  assign rvalid1    = rvalid1_r;
  assign rdata      = ram_dataout;
  assign ram_addr   = ram_addr_s;
  assign ram_datain = ram_datain_s;
  assign ram_we     = ram_we_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scenario bench for ram_arbiter with a behavioural 1-cycle-latency RAM and
// a per-requester read-data scoreboard.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_datain;
  logic        ram_we;
  logic [7:0]  ram_dataout;

  int          total = 0;
  int          bad = 0;
  logic        preload;
  logic [7:0]  mem    [0:255];
  logic [7:0]  shadow [0:255];
  logic [7:0]  exp0 [$];
  logic [7:0]  exp1 [$];

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_datain(ram_datain),
    .ram_we(ram_we), .ram_dataout(ram_dataout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int i);
    return 8'(i * 37 + 11);
  endfunction

  // Behavioural synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_datain;
    end
    ram_dataout <= mem[ram_addr[7:0]];
  end

  // Read-data scoreboard: every rvalid pops the next expected value.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rvalid0 === 1'b1) begin
      total++;
      if (exp0.size() == 0) begin
        bad++; $display("FAIL sb_rvalid0 unexpected rvalid0, rdata=%0h", rdata);
      end else begin
        e = exp0.pop_front();
        if (rdata !== e) begin bad++; $display("FAIL sb_rdata0 got=%0h exp=%0h", rdata, e); end
      end
    end
    if (rvalid1 === 1'b1) begin
      total++;
      if (exp1.size() == 0) begin
        bad++; $display("FAIL sb_rvalid1 unexpected rvalid1, rdata=%0h", rdata);
      end else begin
        e = exp1.pop_front();
        if (rdata !== e) begin bad++; $display("FAIL sb_rdata1 got=%0h exp=%0h", rdata, e); end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; preload = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; lock0 = 1'b1; lock1 = 1'b1;
    addr0 = 16'd5; addr1 = 16'd9; wdata0 = 8'h11; wdata1 = 8'h22;
    repeat (3) @(posedge clk);
    #4;
    total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", gnt0, gnt1); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    total++; if ({rvalid0, rvalid1} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
    preload = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 16'h1234; addr1 = 16'h0456; wdata0 = 8'h77; wdata1 = 8'h88;
    next_cycle();
    rst_n = 1'b1;
    #3;
    total++; if ({gnt0, gnt1, ram_we} !== 3'b000) begin bad++; $display("FAIL nogrant_ctl got=%b%b%b exp=000", gnt0, gnt1, ram_we); end
    total++; if (ram_addr !== 16'd0 || ram_datain !== 8'd0) begin bad++; $display("FAIL nogrant_bus got=%0h/%0h exp=0/0", ram_addr, ram_datain); end
  endtask

  task automatic test_tie();
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd5; req1 = 1'b1; we1 = 1'b0; addr1 = 16'd9;
    #3;
    total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL tie_c1_gnt got=%b%b exp=10", gnt0, gnt1); end
    total++; if (ram_addr !== 16'd5 || ram_we !== 1'b0) begin bad++; $display("FAIL tie_c1_bus got=%0h/%b exp=5/0", ram_addr, ram_we); end
    exp0.push_back(shadow[5]);
    next_cycle();
    req0 = 1'b0;
    #3;
    total++; if ({gnt0, gnt1} !== 2'b01) begin bad++; $display("FAIL tie_c2_gnt got=%b%b exp=01", gnt0, gnt1); end
    total++; if (ram_addr !== 16'd9) begin bad++; $display("FAIL tie_c2_addr got=%0h exp=9", ram_addr); end
    total++; if (rvalid0 !== 1'b1) begin bad++; $display("FAIL tie_c2_rvalid0 got=%b exp=1", rvalid0); end
    exp1.push_back(shadow[9]);
    next_cycle();
    req1 = 1'b0;
    #3;
    total++; if ({rvalid0, rvalid1} !== 2'b01) begin bad++; $display("FAIL tie_c3_rvalid got=%b%b exp=01", rvalid0, rvalid1); end
  endtask

  task automatic test_lock_write();
    next_cycle();
    req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 16'd3; wdata0 = 8'hAA;
    req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 16'd3;
    #3;
    total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL lockw_gnt got=%b%b exp=10", gnt0, gnt1); end
    total++; if (ram_we !== 1'b1 || ram_addr !== 16'd3 || ram_datain !== 8'hAA) begin
      bad++; $display("FAIL lockw_bus got=%b/%0h/%0h exp=1/3/aa", ram_we, ram_addr, ram_datain); end
    shadow[3] = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req0 = 1'b0; we0 = 1'b0;
      #3;
      total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL lockw_hold%0d got=%b%b exp=00", k, gnt0, gnt1); end
      total++; if (ram_addr !== 16'd0 || ram_we !== 1'b0) begin bad++; $display("FAIL lockw_quiet%0d got=%0h/%b exp=0/0", k, ram_addr, ram_we); end
    end
    next_cycle();
    lock0 = 1'b0;
    #3;
    total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL lockw_release_cycle got=%b exp=0", gnt1); end
    next_cycle();
    #3;
    total++; if (gnt1 !== 1'b1 || ram_addr !== 16'd3 || ram_we !== 1'b0) begin
      bad++; $display("FAIL lockw_gnt1 got=%b/%0h/%b exp=1/3/0", gnt1, ram_addr, ram_we); end
    exp1.push_back(shadow[3]);
    next_cycle();
    req1 = 1'b0;
    #3;
    total++; if (rvalid1 !== 1'b1) begin bad++; $display("FAIL lockw_rvalid1 got=%b exp=1", rvalid1); end
  endtask

  task automatic test_lock_timeout();
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 16'd7;
    req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 16'd12;
    #3;
    total++; if ({gnt0, gnt1} !== 2'b10 || ram_addr !== 16'd7) begin
      bad++; $display("FAIL tmo_first got=%b%b/%0h exp=10/7", gnt0, gnt1, ram_addr); end
    exp0.push_back(shadow[7]);
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      req0 = 1'b0;
      #3;
      total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL tmo_idle%0d got=%b exp=0", k, gnt1); end
    end
    next_cycle();
    #3;
    total++; if (gnt1 !== 1'b1 || ram_addr !== 16'd12) begin bad++; $display("FAIL tmo_c16 got=%b/%0h exp=1/c", gnt1, ram_addr); end
    exp1.push_back(shadow[12]);
    next_cycle();
    req1 = 1'b0; lock0 = 1'b0;
    #3;
    total++; if (rvalid1 !== 1'b1) begin bad++; $display("FAIL tmo_rvalid1 got=%b exp=1", rvalid1); end
  endtask

  task automatic test_burst_read();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 16'(i);
      #3;
      total++; if (gnt1 !== 1'b1 || ram_addr !== 16'(i)) begin bad++; $display("FAIL burst_gnt%0d got=%b/%0h exp=1/%0h", i, gnt1, ram_addr, i); end
      total++; if (rvalid1 !== (i > 0)) begin bad++; $display("FAIL burst_rvalid%0d got=%b exp=%b", i, rvalid1, (i > 0)); end
      exp1.push_back(shadow[i]);
    end
    next_cycle();
    req1 = 1'b0;
    #3;
    total++; if (rvalid1 !== 1'b1) begin bad++; $display("FAIL burst_last_rvalid got=%b exp=1", rvalid1); end
    next_cycle();
    #3;
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL burst_after_rvalid got=%b exp=0", rvalid1); end
  endtask

  task automatic test_back_to_back();
    logic e0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 16'd20;
      req1 = 1'b1; we1 = 1'b1; lock1 = 1'b0; addr1 = 16'd30; wdata1 = 8'h5C;
      #3;
      e0 = ((i % 2) == 0);
      total++; if ({gnt0, gnt1} !== {e0, ~e0}) begin bad++; $display("FAIL b2b_gnt%0d got=%b%b exp=%b%b", i, gnt0, gnt1, e0, ~e0); end
      total++; if (ram_we !== ~e0 || ram_addr !== (e0 ? 16'd20 : 16'd30)) begin
        bad++; $display("FAIL b2b_bus%0d got=%b/%0h exp=%b/%0h", i, ram_we, ram_addr, ~e0, (e0 ? 16'd20 : 16'd30)); end
      if (e0) exp0.push_back(shadow[20]);
      else shadow[30] = 8'h5C;
    end
    next_cycle();
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    #3;
    total++; if ({rvalid0, rvalid1} !== 2'b00) begin bad++; $display("FAIL b2b_write_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
  endtask

  task automatic test_reset_mid_lock();
    next_cycle();
    req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 16'd40;
    #3;
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL rml_own1 got=%b exp=1", gnt1); end
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 16'd30;
    #1;
    rst_n = 1'b0;
    #2;
    total++; if ({gnt0, gnt1, ram_we} !== 3'b000) begin bad++; $display("FAIL rml_in_reset got=%b%b%b exp=000", gnt0, gnt1, ram_we); end
    total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL rml_rvalid_drop got=%b exp=0", rvalid1); end
    next_cycle();
    total++; if ({gnt0, gnt1, rvalid1} !== 3'b000) begin bad++; $display("FAIL rml_held got=%b%b%b exp=000", gnt0, gnt1, rvalid1); end
    rst_n = 1'b1;
    #3;
    total++; if ({gnt0, gnt1} !== 2'b10 || ram_addr !== 16'd30) begin
      bad++; $display("FAIL rml_first got=%b%b/%0h exp=10/1e", gnt0, gnt1, ram_addr); end
    exp0.push_back(shadow[30]);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    #3;
    total++; if ({rvalid0, rvalid1} !== 2'b10) begin bad++; $display("FAIL rml_after got=%b%b exp=10", rvalid0, rvalid1); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    test_reset();
    test_tie();
    test_lock_write();
    test_lock_timeout();
    test_burst_read();
    test_back_to_back();
    test_reset_mid_lock();
    repeat (3) next_cycle();
    total++; if (exp0.size() != 0) begin bad++; $display("FAIL sb_pending0 got=%0d exp=0", exp0.size()); end
    total++; if (exp1.size() != 0) begin bad++; $display("FAIL sb_pending1 got=%0d exp=0", exp1.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
